// File: rtl/and_frame_monitor_pkg.sv
// Shared definitions for the AND-stage frame monitor: FSM encodings and
// width helpers used to size the accumulators and the sample counter.
package and_frame_monitor_pkg;

    // Frame FSM encodings, kept as plain 2-bit constants for legacy tools.
    localparam logic [1:0] FRM_IDLE  = 2'd0;
    localparam logic [1:0] FRM_ACCUM = 2'd1;
    localparam logic [1:0] FRM_DONE  = 2'd2;

    // Bits needed to hold a set-bit total of up to frame_len*width.
    function automatic int ones_width(input int frame_len, input int width);
        return $clog2(frame_len * width + 1);
    endfunction

    // Bits needed to count from 0 up to frame_len samples.
    function automatic int cnt_width(input int frame_len);
        return $clog2(frame_len + 1);
    endfunction

    // Bits needed for the popcount of a single width-bit sample.
    function automatic int pop_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/and_frame_monitor_popcount_comb.sv
// Purely combinational population count of one WIDTH-bit vector.
module popcount_comb
    import and_frame_monitor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]            vec_i,
    output logic [pop_width(WIDTH)-1:0] count_o
);

    localparam int PW = pop_width(WIDTH);

    // Sum the individual bits of the vector.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_o = count_o + PW'(vec_i[i]);
        end
    end

endmodule

// File: rtl/and_frame_monitor.sv
// Frame statistics over the registered AND-stage output: per frame of
// FRAME_LEN accepted samples it reports the total set-bit count, the per-bit
// OR and the per-bit AND, then holds the result on a valid/ready handshake.
module and_frame_monitor
    import and_frame_monitor_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int FRAME_LEN = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [WIDTH-1:0]                       in_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [ones_width(FRAME_LEN, WIDTH)-1:0] out_ones,
    output logic [WIDTH-1:0]                       out_any,
    output logic [WIDTH-1:0]                       out_all
);

    localparam int ONES_W = ones_width(FRAME_LEN, WIDTH);
    localparam int CNT_W  = cnt_width(FRAME_LEN);
    localparam int POP_W  = pop_width(WIDTH);

    // The sample that arrives while the counter holds LAST_CNT closes the frame.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [ONES_W-1:0] ones_q,  ones_d;
    logic [WIDTH-1:0]  any_q,   any_d;
    logic [WIDTH-1:0]  all_q,   all_d;

    logic [POP_W-1:0]  pop;
    logic              accept;

    popcount_comb #(
        .WIDTH (WIDTH)
    ) u_popcount (
        .vec_i   (in_data),
        .count_o (pop)
    );

    // Handshake flags depend on the state register only.
    assign in_ready  = (state_q != FRM_DONE);
    assign out_valid = (state_q == FRM_DONE);
    assign accept    = in_valid && in_ready;

    assign out_ones  = ones_q;
    assign out_any   = any_q;
    assign out_all   = all_q;

    // Next-state and accumulator update; anything not accepted holds.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ones_d  = ones_q;
        any_d   = any_q;
        all_d   = all_q;
        case (state_q)
            FRM_IDLE: begin
                if (accept) begin
                    ones_d  = ONES_W'(pop);
                    any_d   = in_data;
                    all_d   = in_data;
                    cnt_d   = ONE_CNT;
                    state_d = (FRAME_LEN == 1) ? FRM_DONE : FRM_ACCUM;
                end
            end
            FRM_ACCUM: begin
                if (accept) begin
                    ones_d = ones_q + ONES_W'(pop);
                    any_d  = any_q | in_data;
                    all_d  = all_q & in_data;
                    cnt_d  = cnt_q + ONE_CNT;
                    if (cnt_q == LAST_CNT) begin
                        state_d = FRM_DONE;
                    end
                end
            end
            FRM_DONE: begin
                // Result stays frozen until the consumer takes it.
                if (out_ready) begin
                    state_d = FRM_IDLE;
                end
            end
            default: begin
                state_d = FRM_IDLE;
            end
        endcase
    end

    // State and accumulator registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FRM_IDLE;
            cnt_q   <= '0;
            ones_q  <= '0;
            any_q   <= '0;
            all_q   <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ones_q  <= ones_d;
            any_q   <= any_d;
            all_q   <= all_d;
        end
    end

endmodule

// File: tb/tb_and_frame_monitor.sv
// Directed bench for and_frame_monitor: a FRAME_LEN=4 instance driven from a
// table of frames plus hand-written corner sequences, and a FRAME_LEN=1 instance.
module tb_and_frame_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // FRAME_LEN = 4 instance
    logic       rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [3:0] in_data, out_any, out_all;
    logic [4:0] out_ones;

    and_frame_monitor #(.WIDTH(4), .FRAME_LEN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ones  (out_ones),
        .out_any   (out_any),
        .out_all   (out_all)
    );

    // FRAME_LEN = 1 instance
    logic       rst1_n, in1_valid, in1_ready, out1_valid, out1_ready;
    logic [3:0] in1_data, out1_any, out1_all;
    logic [2:0] out1_ones;

    and_frame_monitor #(.WIDTH(4), .FRAME_LEN(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst1_n),
        .in_valid  (in1_valid),
        .in_ready  (in1_ready),
        .in_data   (in1_data),
        .out_valid (out1_valid),
        .out_ready (out1_ready),
        .out_ones  (out1_ones),
        .out_any   (out1_any),
        .out_all   (out1_all)
    );

    typedef struct {
        logic [3:0][3:0] samp;   // samp[0] is sent first
        logic [4:0]      ones;
        logic [3:0]      any_v;
        logic [3:0]      all_v;
    } frame_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send four samples; with gaps, an idle cycle precedes every sample but the first.
    task automatic send_frame(input logic [3:0][3:0] s, input bit gaps);
        for (int i = 0; i < 4; i++) begin
            if (gaps && i > 0) begin
                in_valid = 1'b0;
                in_data  = 4'hF;
                tick();
                chk("gap_in_ready", in_ready, 1);
                chk("gap_out_valid", out_valid, 0);
            end
            in_valid = 1'b1;
            in_data  = s[i];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic chk_result(input string tag, input frame_t f);
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_in_ready"},  in_ready, 0);
        chk({tag, "_ones"},      out_ones, f.ones);
        chk({tag, "_any"},       out_any, f.any_v);
        chk({tag, "_all"},       out_all, f.all_v);
    endtask

    frame_t tbl [5];
    frame_t basic;
    logic [4:0] hold_ones;

    initial begin
        tbl[0] = '{samp: {4'hB, 4'h2, 4'hE, 4'hA}, ones: 5'd9,  any_v: 4'hF, all_v: 4'h2};
        tbl[1] = '{samp: {4'hF, 4'hF, 4'hF, 4'hF}, ones: 5'd16, any_v: 4'hF, all_v: 4'hF};
        tbl[2] = '{samp: {4'h8, 4'h4, 4'h2, 4'h1}, ones: 5'd4,  any_v: 4'hF, all_v: 4'h0};
        tbl[3] = '{samp: {4'h0, 4'h0, 4'h0, 4'h0}, ones: 5'd0,  any_v: 4'h0, all_v: 4'h0};
        tbl[4] = '{samp: {4'h7, 4'h6, 4'h7, 4'h7}, ones: 5'd11, any_v: 4'h7, all_v: 4'h6};
        basic  = tbl[0];

        rst_n = 1'b0; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b1;
        rst1_n = 1'b0; in1_valid = 1'b0; in1_data = 4'h0; out1_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready",  in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ones",      out_ones, 0);
        chk("rst_any",       out_any, 0);
        chk("rst_all",       out_all, 4'hF);
        chk("rst1_out_valid", out1_valid, 0);
        rst_n = 1'b1;
        rst1_n = 1'b1;

        // Table of back-to-back frames with out_ready tied high.
        for (int k = 0; k < 5; k++) begin
            send_frame(tbl[k].samp, 1'b0);
            chk_result($sformatf("tbl%0d", k), tbl[k]);
            tick();
            chk($sformatf("tbl%0d_ready_back", k), in_ready, 1);
            chk($sformatf("tbl%0d_valid_drop", k), out_valid, 0);
        end

        // Basic frame with gaps in in_valid.
        send_frame(basic.samp, 1'b1);
        chk_result("gaps", basic);
        tick();
        chk("gaps_ready_back", in_ready, 1);

        // Backpressure: hold out_ready low for 5 cycles with stray in_valid pulses.
        out_ready = 1'b0;
        send_frame(tbl[4].samp, 1'b0);
        chk_result("bp0", tbl[4]);
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0];
            in_data  = 4'hF;
            tick();
            chk_result($sformatf("bp%0d", c + 1), tbl[4]);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_consumed_valid", out_valid, 0);
        chk("bp_consumed_ready", in_ready, 1);

        // Reset mid-frame discards the partial frame.
        in_valid = 1'b1;
        in_data  = 4'hF;
        tick();
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_ones",     out_ones, 0);
        send_frame(basic.samp, 1'b0);
        chk_result("midrst", basic);
        tick();

        // Reset while the result is pending.
        out_ready = 1'b0;
        send_frame(tbl[1].samp, 1'b0);
        chk("donerst_pre", out_valid, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        chk("donerst_valid", out_valid, 0);
        chk("donerst_ready", in_ready, 1);
        chk("donerst_all",   out_all, 4'hF);

        // FRAME_LEN = 1: one sample completes the frame.
        out1_ready = 1'b0;
        in1_valid = 1'b1;
        in1_data  = 4'h6;
        tick();
        in1_valid = 1'b0;
        chk("fl1_valid", out1_valid, 1);
        chk("fl1_ready", in1_ready, 0);
        chk("fl1_ones",  out1_ones, 2);
        chk("fl1_any",   out1_any, 4'h6);
        chk("fl1_all",   out1_all, 4'h6);
        hold_ones = 5'(out1_ones);
        in1_valid = 1'b1;
        in1_data  = 4'hF;
        tick();
        in1_valid = 1'b0;
        chk("fl1_hold_ones", 32'(hold_ones), 2);
        chk("fl1_hold_ones2", out1_ones, 2);
        out1_ready = 1'b1;
        tick();
        chk("fl1_consumed", out1_valid, 0);
        chk("fl1_ready_back", in1_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
